// File: rtl/pwm_pkg.sv
// Definitions shared by the PWM generator and its capture counterpart.
package pwm_pkg;

    localparam int PWM_DUTY_W = 4;
    localparam int PWM_PERIOD = 16;
    localparam int PWM_DUTY_MAX = (1 << PWM_DUTY_W) - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HIGH  = 2'd1,
        ST_LOW   = 2'd2,
        ST_STUCK = 2'd3
    } cap_state_t;

    // High time to duty code, clamped at full scale.
    function automatic logic [PWM_DUTY_W-1:0] duty_from_cnt(input int unsigned cnt);
        if (cnt > PWM_DUTY_MAX)
            return PWM_DUTY_W'(PWM_DUTY_MAX);
        return PWM_DUTY_W'(cnt);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer plus delay flop, giving one-cycle rise/fall pulses.
// Edges stay masked until the delay flop holds a real sample, so a level present at reset release is not an edge.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic       meta;
    logic       sync_d;
    logic [2:0] fill;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta     <= 1'b0;
            sync_out <= 1'b0;
            sync_d   <= 1'b0;
            fill     <= '0;
        end else begin
            meta     <= din;
            sync_out <= meta;
            sync_d   <= sync_out;
            fill     <= {fill[1:0], 1'b1};
        end
    end

    assign rise = fill[2] & sync_out & ~sync_d;
    assign fall = fill[2] & ~sync_out & sync_d;

endmodule

// File: rtl/pwm_capture_4bit.sv
// Measures high time and rise-to-rise period of an incoming PWM waveform and
// recovers its duty code; flags a stuck input after TIMEOUT clocks without an edge.
//
// state    | meaning
// IDLE     | after reset, waiting for the first rise (partial frame discarded)
// HIGH     | input high, counting high time and period
// LOW      | input low, counting period; next rise completes the frame
// STUCK    | no edge for TIMEOUT clocks; result reported once, waiting for a rise
module pwm_capture_4bit
    import pwm_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int PERIOD  = PWM_PERIOD,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pwm_in,
    output logic [PWM_DUTY_W-1:0] duty_out,
    output logic [CNT_W-1:0]      high_cnt,
    output logic [CNT_W-1:0]      period_cnt,
    output logic                  period_ok,
    output logic                  duty_valid,
    output logic                  timeout
);

    localparam logic [CNT_W-1:0]      CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]      TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]      PERIOD_C  = CNT_W'(PERIOD);
    localparam logic [PWM_DUTY_W-1:0] DUTY_ALL  = '1;

    logic pwm_s, rise, fall;

    sync_edge_det u_sync (
        .clk      (clk),
        .rst      (rst),
        .din      (pwm_in),
        .sync_out (pwm_s),
        .rise     (rise),
        .fall     (fall)
    );

    cap_state_t state, state_nxt;
    logic [CNT_W-1:0]      hcnt, pcnt, idle_cnt;
    logic [CNT_W-1:0]      hcnt_nxt, pcnt_nxt, hcnt_inc, pcnt_inc;
    logic [CNT_W-1:0]      high_nxt, period_nxt;
    logic [PWM_DUTY_W-1:0] duty_nxt;
    logic                  ok_nxt, valid_nxt, timeout_nxt, expire;

    assign hcnt_inc = (hcnt == CNT_MAX) ? hcnt : hcnt + CNT_ONE;
    assign pcnt_inc = (pcnt == CNT_MAX) ? pcnt : pcnt + CNT_ONE;

    // Any edge this cycle pre-empts the stuck decision.
    assign expire = (idle_cnt >= TIMEOUT_C) && !rise && !fall && (state != ST_STUCK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            idle_cnt <= '0;
        else if (rise || fall)
            idle_cnt <= CNT_ONE;
        else if (idle_cnt != CNT_MAX)
            idle_cnt <= idle_cnt + CNT_ONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        hcnt_nxt    = hcnt;
        pcnt_nxt    = pcnt;
        duty_nxt    = duty_out;
        high_nxt    = high_cnt;
        period_nxt  = period_cnt;
        ok_nxt      = period_ok;
        timeout_nxt = timeout;
        valid_nxt   = 1'b0;
        if (expire) begin
            state_nxt   = ST_STUCK;
            valid_nxt   = 1'b1;
            timeout_nxt = 1'b1;
            duty_nxt    = pwm_s ? DUTY_ALL : '0;
            high_nxt    = '0;
            period_nxt  = '0;
            ok_nxt      = 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_STUCK: begin
                    if (rise) begin
                        state_nxt = ST_HIGH;
                        hcnt_nxt  = CNT_ONE;
                        pcnt_nxt  = CNT_ONE;
                    end
                end
                ST_HIGH: begin
                    pcnt_nxt = pcnt_inc;
                    if (fall)
                        state_nxt = ST_LOW;
                    else
                        hcnt_nxt = hcnt_inc;
                end
                ST_LOW: begin
                    if (rise) begin
                        state_nxt   = ST_HIGH;
                        high_nxt    = hcnt;
                        period_nxt  = pcnt;
                        duty_nxt    = duty_from_cnt(32'(hcnt));
                        ok_nxt      = (pcnt == PERIOD_C);
                        valid_nxt   = 1'b1;
                        timeout_nxt = 1'b0;
                        hcnt_nxt    = CNT_ONE;
                        pcnt_nxt    = CNT_ONE;
                    end else begin
                        pcnt_nxt = pcnt_inc;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt       <= '0;
            pcnt       <= '0;
            duty_out   <= '0;
            high_cnt   <= '0;
            period_cnt <= '0;
            period_ok  <= 1'b0;
            duty_valid <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            hcnt       <= hcnt_nxt;
            pcnt       <= pcnt_nxt;
            duty_out   <= duty_nxt;
            high_cnt   <= high_nxt;
            period_cnt <= period_nxt;
            period_ok  <= ok_nxt;
            duty_valid <= valid_nxt;
            timeout    <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_pwm_capture_4bit.sv
// Scoreboard bench for pwm_capture_4bit: waveform segments feed a frame-level
// reference model; a monitor checks every duty_valid strobe against it.
module tb_pwm_capture_4bit;

    localparam int CNT_W   = 8;
    localparam int PERIOD  = 16;
    localparam int TIMEOUT = 64;
    localparam int LAT     = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             pwm_in;
    logic [3:0]       duty_out;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] period_cnt;
    logic             period_ok;
    logic             duty_valid;
    logic             timeout;

    pwm_capture_4bit #(.CNT_W(CNT_W), .PERIOD(PERIOD), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .pwm_in     (pwm_in),
        .duty_out   (duty_out),
        .high_cnt   (high_cnt),
        .period_cnt (period_cnt),
        .period_ok  (period_ok),
        .duty_valid (duty_valid),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          duty;
        int          high;
        int          period;
        bit          ok;
        bit          tmo;
        int unsigned at;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: frame bookkeeping in terms of whole waveform segments.
    bit m_open  = 0;
    bit m_stuck = 0;
    int m_high  = 0;
    int m_low   = 0;

    function automatic int duty_of(input int h);
        return (h > 15) ? 15 : h;
    endfunction

    task automatic push_exp(input int d, input int h, input int p, input bit ok,
                            input bit tmo, input int unsigned at);
        exp_t e;
        e.duty = d; e.high = h; e.period = p; e.ok = ok; e.tmo = tmo; e.at = at;
        sb.push_back(e);
    endtask

    // Drive one level for len sampling edges; the level must differ from the previous one.
    task automatic seg(input bit lvl, input int len);
        int unsigned c0;
        c0 = cyc;
        pwm_in = lvl;
        if (lvl) begin
            if (m_open && m_low > 0)
                push_exp(duty_of(m_high), m_high, m_high + m_low,
                         (m_high + m_low) == PERIOD, 1'b0, c0 + LAT);
            m_open  = 1;
            m_stuck = 0;
            m_high  = len;
            m_low   = 0;
        end else if (m_open) begin
            m_low = len;
        end
        if (len > TIMEOUT && !m_stuck) begin
            push_exp(lvl ? 15 : 0, 0, 0, 1'b0, 1'b1, c0 + TIMEOUT + LAT);
            m_stuck = 1;
            m_open  = 0;
        end
        repeat (len) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_duty"},    32'(duty_out),   0);
        chk({tag, "_high"},    32'(high_cnt),   0);
        chk({tag, "_period"},  32'(period_cnt), 0);
        chk({tag, "_ok"},      32'(period_ok),  0);
        chk({tag, "_valid"},   32'(duty_valid), 0);
        chk({tag, "_timeout"}, 32'(timeout),    0);
    endtask

    bit prev_v = 0;
    always @(negedge clk) begin
        if (rst) begin
            prev_v = 0;
        end else begin
            if (duty_valid) begin
                n_tests++;
                if (prev_v) begin
                    n_fail++;
                    $display("FAIL strobe_back_to_back: duty_valid high two cycles running at cyc %0d", cyc);
                end
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_strobe: got duty=%0d high=%0d period=%0d at cyc %0d, expected no strobe",
                             duty_out, high_cnt, period_cnt, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (duty_out !== 4'(e.duty) || high_cnt !== CNT_W'(e.high) ||
                        period_cnt !== CNT_W'(e.period) || period_ok !== e.ok ||
                        timeout !== e.tmo || cyc != e.at) begin
                        n_fail++;
                        $display("FAIL strobe: got duty=%0d high=%0d period=%0d ok=%0b tmo=%0b cyc=%0d, expected duty=%0d high=%0d period=%0d ok=%0b tmo=%0b cyc=%0d",
                                 duty_out, high_cnt, period_cnt, period_ok, timeout, cyc,
                                 e.duty, e.high, e.period, e.ok, e.tmo, e.at);
                    end
                end
            end
            prev_v = duty_valid;
        end
    end

    initial begin
        rst    = 1'b1;
        pwm_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        rst = 1'b0;
        seg(0, 10);

        // Loopback-style duty 4, then sweep 8 / 12 / 15.
        repeat (4) begin seg(1, 4);  seg(0, 12); end
        repeat (3) begin seg(1, 8);  seg(0, 8);  end
        repeat (3) begin seg(1, 12); seg(0, 4);  end
        repeat (3) begin seg(1, 15); seg(0, 1);  end

        // Duty 0 (stuck low), then recovery at duty 6.
        seg(1, 3);
        seg(0, 100);
        seg(1, 6);
        chk("timeout_held_after_stuck_low", 32'(timeout), 1);
        seg(0, 10);
        repeat (2) begin seg(1, 6); seg(0, 10); end

        // Stuck high.
        seg(1, 80);
        seg(0, 10);
        repeat (2) begin seg(1, 4); seg(0, 12); end

        // Off-period 5 high / 15 low.
        repeat (3) begin seg(1, 5); seg(0, 15); end

        // Timeout boundary: an edge exactly at TIMEOUT wins; one clock more expires.
        seg(1, TIMEOUT);
        seg(0, 3);
        seg(1, 3);
        seg(0, TIMEOUT);
        seg(1, 5);
        seg(0, TIMEOUT + 1);
        seg(1, 5);
        chk("timeout_held_boundary", 32'(timeout), 1);
        seg(0, 11);
        seg(1, 20);
        seg(0, 5);

        // Randomized frames: generator-like codes, free-form lengths, occasional stuck segments.
        for (int i = 0; i < 40; i++) begin
            int h, l, k;
            k = int'($urandom_range(0, 9));
            if (k < 4) begin
                h = int'($urandom_range(1, 15));
                l = PERIOD - h;
            end else begin
                h = int'($urandom_range(1, 40));
                l = int'($urandom_range(1, 40));
            end
            if (k == 8) h = int'($urandom_range(TIMEOUT + 2, TIMEOUT + 30));
            if (k == 9) l = int'($urandom_range(TIMEOUT + 2, TIMEOUT + 30));
            seg(1, h);
            seg(0, l);
        end

        // Reset during a high phase.
        seg(1, 7);
        seg(0, 10);
        chk("sb_empty_before_reset", 32'(sb.size()), 0);
        pwm_in = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk_outputs_zero("reset_mid_high");
        sb.delete();
        m_open  = 0;
        m_stuck = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        seg(0, 9);
        repeat (3) begin seg(1, 7); seg(0, 9); end
        seg(1, 2);
        seg(0, 10);

        chk("sb_drained", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_capture_4bit.md
# pwm_capture_4bit

- Receive-side counterpart of `pwm_4bit`. Samples an incoming PWM waveform and measures high time and period between rising edges.
- Reports the recovered 4-bit duty code with a one-cycle valid strobe.
- Used for loopback self-test of the PWM generator, and for decoding PWM produced by external sources with the same 16-cycle frame.

## Interface
Parameters:
- `CNT_W`, 8: width of the high-time and period counters. Must be at least 5.
- `PERIOD`, 16: expected frame length in clocks. Used only for `period_ok`.
- `TIMEOUT`, 64: number of clocks without an edge that declares the input stuck. Must be greater than `PERIOD` and less than 2^`CNT_W`.

Ports:
- `clk` input 1: single system clock, rising-edge.
- `rst` input 1: reset, asynchronous and active-high. All state clears immediately.
- `pwm_in` input 1: PWM waveform, asynchronous to `clk`.
- `duty_out` output 4: recovered duty code. Reset value 0.
- `high_cnt` output `CNT_W`: last measured high time in clocks. Reset value 0.
- `period_cnt` output `CNT_W`: last measured rise-to-rise period in clocks. Reset value 0.
- `period_ok` output 1: high when `period_cnt == PERIOD`. Reset value 0.
- `duty_valid` output 1: one-cycle strobe; all result outputs update in the same cycle. Reset value 0.
- `timeout` output 1: input stuck, no edge for `TIMEOUT` clocks. Reset value 0.

## Operation
Input conditioning:
- `pwm_in` passes through a 2-flop synchronizer to give `pwm_s`.
- A third flop holds the previous value, `pwm_d`.
- `rise = pwm_s & ~pwm_d`.
- `fall = ~pwm_s & pwm_d`.

FSM states: IDLE, HIGH, LOW, STUCK.
- **IDLE** (entered from reset):
  - Waits for `rise` and discards any partial frame.
  - `rise` → HIGH, with `hcnt = 1` and `pcnt = 1`.
- **HIGH**:
  - Each cycle: `hcnt++` and `pcnt++`.
  - `fall` → LOW; the falling cycle is not counted as high.
- **LOW**:
  - Each cycle: `pcnt++`.
  - On `rise`, latch results: `high_cnt = hcnt`, `period_cnt = pcnt`, `duty_out = min(hcnt, 15)`.
  - In the same cycle, pulse `duty_valid`, update `period_ok`, and clear `timeout`.
  - Then return to HIGH with `hcnt = 1` and `pcnt = 1`.
- **STUCK**:
  - Entered from any state when `idle_cnt` reaches `TIMEOUT`. `idle_cnt` counts clocks since the last `rise` or `fall`.
  - On entry, pulse `duty_valid` once and set `timeout = 1`. If `pwm_s` is low: `duty_out = 0`. If high: `duty_out = 15`.
  - Also on entry: `high_cnt = 0`, `period_cnt = 0`, `period_ok = 0`.
  - Stays in STUCK with no further strobes.
  - `rise` → HIGH, with counters restarted at 1 and `timeout` held until the next completed frame.

Arithmetic and boundaries:
- `hcnt`, `pcnt` and `idle_cnt` saturate at all-ones and never wrap.
- `duty_out` saturates at 15 when `hcnt > 15`.
- A measured high time of 0 cannot occur: any rise produces at least one high cycle. Duty 0 is reported only through STUCK.
- A `rise` and a `TIMEOUT` expiry in the same cycle: `rise` wins and STUCK is not entered.
- Reset asserted mid-frame: all outputs return to their reset values at once. The first result after reset requires one full frame (IDLE discards the partial frame).

## Timing
- Synchronizer latency: `pwm_s` reflects `pwm_in` 2 clocks after the sampling edge. Both edges see the same latency, so `high_cnt` and `period_cnt` are exact for inputs synchronous to `clk`.
- `duty_valid` asserts in the cycle `rise` is detected, 3 clocks after the first sampling edge at which `pwm_in` is high.
- The first `duty_valid` after reset requires two rising edges.
- `duty_valid` is never high for 2 consecutive cycles.
- Results hold their values between strobes.
- Matched to `pwm_4bit` with code d, 1 ≤ d ≤ 15:
  - strobe every 16 clocks;
  - `high_cnt = d`, `duty_out = d`;
  - `period_cnt = 16`, `period_ok = 1`.

## Structure
- Shared package `pwm_pkg`:
  - FSM state encoding (IDLE, HIGH, LOW, STUCK);
  - `PWM_DUTY_W = 4`;
  - default `PERIOD = 16`, shared with `pwm_4bit`.
- One natural sub-module: `sync_edge_det`, containing the 2-flop synchronizer, the delay flop, and the `rise`/`fall` outputs. It is reusable for other asynchronous inputs.
- FSM, counters and output registers stay in `pwm_capture_4bit`.

## Test plan
- **Loopback d=4:** `pwm_4bit` (duty 4) drives `pwm_in`. After the first two frames: `duty_valid` every 16 clocks, `duty_out = 4`, `high_cnt = 4`, `period_cnt = 16`, `period_ok = 1`, `timeout = 0`.
- **Duty sweep:** duty 4 → 8 → 12 → 15, 200 ns each at 10 ns clock. After at most 2 strobes per step, `duty_out` tracks 8, 12 and 15, and `period_ok` stays 1.
- **Duty 0:** `pwm_in` held low for 100 clocks. After 64 clocks without an edge: a single `duty_valid`, `timeout = 1`, `duty_out = 0`, `period_cnt = 0`. Returning to duty 6 clears `timeout` at the first completed frame, with `duty_out = 6`.
- **Stuck high:** `pwm_in` held high for more than 64 clocks. Expect `timeout = 1`, `duty_out = 15`, and one strobe only.
- **Off-period:** hand-driven waveform, 5 high / 15 low. Expect `high_cnt = 5`, `period_cnt = 20`, `duty_out = 5`, `period_ok = 0`.
- **Reset mid-high:** assert `rst` for 3 clocks during a high phase. Outputs go to 0 immediately. The first new strobe arrives only after two subsequent rising edges, with correct values.
